// File: rtl/aes_byte_display_pkg.sv
// Shared definitions for the AES result byte display path.
// Provides the FSM state type, active-low 7-segment codes, datapath widths
// and the double-dabble nibble adjust step.
package aes_disp_pkg;

  localparam int BYTE_W = 8;
  localparam int BCD_W  = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_e;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Any BCD nibble of 5 or more gets +3 so the following left shift carries
  // correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_byte_display_if.sv
// Bus bundle between the AES core side and the display stage.
//   data_in/data_valid : result word and its 1-cycle capture strobe
//   sel                : byte index from the board switches (0 = MSB byte)
//   hex0/hex1/hex2     : units/tens/hundreds, active-low {g,f,e,d,c,b,a}
//   busy/done          : conversion in progress / new digits shown
// master drives the word and index; slave is the display stage.
interface aes_disp_if;
  import aes_disp_pkg::*;

  logic [16*BYTE_W-1:0] data_in;
  logic                 data_valid;
  logic [3:0]           sel;
  logic [6:0]           hex0;
  logic [6:0]           hex1;
  logic [6:0]           hex2;
  logic                 busy;
  logic                 done;

  modport master (
    output data_in, data_valid, sel,
    input  hex0, hex1, hex2, busy, done
  );

  modport slave (
    input  data_in, data_valid, sel,
    output hex0, hex1, hex2, busy, done
  );

endinterface

// File: rtl/aes_byte_display_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder.
//   nib_i : one BCD digit (values above 9 give a blank display)
//   seg_o : segments {g,f,e,d,c,b,a}, 0 = lit
module seg7_decode
  import aes_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/aes_byte_display.sv
// Display stage for the AES-128 core result.
// Captures the 128-bit word on data_valid, picks the byte addressed by sel,
// converts it to three decimal digits with an 8-step serial double-dabble
// and shows them on three active-low 7-segment displays.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : aes_disp_if.slave (data_in, data_valid, sel, hex0..2, busy, done)
// Trigger-to-display latency is 9 cycles; triggers arriving mid-conversion
// collapse into one pending rerun that starts with no idle gap.
module aes_byte_display
  import aes_disp_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  aes_disp_if.slave bus
);

  state_e               state_q, state_d;
  logic [16*BYTE_W-1:0] word_q;
  logic                 word_ok_q;
  logic [3:0]           sel_q;
  logic [BYTE_W-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 pending_q, pending_d;
  logic [6:0]           hex0_q, hex0_d;
  logic [6:0]           hex1_q, hex1_d;
  logic [6:0]           hex2_q, hex2_d;
  logic                 done_q, done_d;

  logic [16*BYTE_W-1:0]      cur_word;
  logic [6:0]                byte_lsb;
  logic [BYTE_W-1:0]         sel_byte;
  logic                      trig;
  logic [BCD_W+BYTE_W-1:0]   dd_shift;
  logic [6:0]                seg0, seg1, seg2;

  // A capture in this cycle takes effect immediately, so a simultaneous
  // sel change converts the new word with the new index.
  assign cur_word = bus.data_valid ? bus.data_in : word_q;
  // Byte k sits at bit 8*(15-k); 15-k is the bitwise inverse of a 4-bit k.
  assign byte_lsb = {~bus.sel, 3'b000};
  assign sel_byte = cur_word[byte_lsb +: BYTE_W];
  assign trig     = bus.data_valid | (word_ok_q & (bus.sel != sel_q));
  assign dd_shift = {bcd_adjust(bcd_q), bin_q} << 1;

  seg7_decode u_dec0 (.nib_i(bcd_q[3:0]),  .seg_o(seg0));
  seg7_decode u_dec1 (.nib_i(bcd_q[7:4]),  .seg_o(seg1));
  seg7_decode u_dec2 (.nib_i(bcd_q[11:8]), .seg_o(seg2));

  // Capture and switch tracking run every cycle regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q    <= '0;
      word_ok_q <= 1'b0;
      sel_q     <= 4'd0;
    end else begin
      sel_q <= bus.sel;
      if (bus.data_valid) begin
        word_q    <= bus.data_in;
        word_ok_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= 3'd0;
      pending_q <= 1'b0;
      hex0_q    <= SEG_BLANK;
      hex1_q    <= SEG_BLANK;
      hex2_q    <= SEG_BLANK;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      hex0_q    <= hex0_d;
      hex1_q    <= hex1_d;
      hex2_q    <= hex2_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    hex0_d    = hex0_q;
    hex1_d    = hex1_q;
    hex2_d    = hex2_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          bin_d   = sel_byte;
          bcd_d   = '0;
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (trig) begin
          pending_d = 1'b1;
        end
        {bcd_d, bin_d} = dd_shift;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        hex0_d = seg0;
        hex1_d = seg1;
        hex2_d = seg2;
        done_d = 1'b1;
        // A trigger landing on this very edge is served like a pending one,
        // otherwise it would be lost on the way back through IDLE.
        if (pending_q || trig) begin
          pending_d = 1'b0;
          bin_d     = sel_byte;
          bcd_d     = '0;
          cnt_d     = 3'd0;
          state_d   = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.hex0 = hex0_q;
  assign bus.hex1 = hex1_q;
  assign bus.hex2 = hex2_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_aes_byte_display.sv
// Randomized self-checking bench for aes_byte_display against a
// cycle-level behavioural model (countdown + decimal arithmetic).
module tb_aes_byte_display;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  aes_disp_if bus ();

  aes_byte_display dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  logic [127:0] m_word;
  logic         m_ok;
  logic [3:0]   m_sel;
  int           m_cnt;
  logic         m_pend;
  int           m_val;
  logic [6:0]   m_hex0, m_hex1, m_hex2;
  logic         m_done;

  localparam logic [127:0] VEC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int pick(input logic [127:0] w, input logic [3:0] s);
    logic [127:0] t;
    t = w >> (8 * (15 - int'(s)));
    return int'(t[7:0]);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'((v / 100) % 10);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic model_reset();
    m_word = '0; m_ok = 1'b0; m_sel = 4'd0; m_cnt = 0; m_pend = 1'b0;
    m_val = 0; m_hex0 = 7'h7f; m_hex1 = 7'h7f; m_hex2 = 7'h7f; m_done = 1'b0;
  endtask

  task automatic model_edge(input logic dv, input logic [127:0] d, input logic [3:0] s);
    logic trig;
    logic [127:0] nw;
    trig = dv || (m_ok && (s != m_sel));
    nw   = dv ? d : m_word;
    m_done = 1'b0;
    if (m_cnt == 0) begin
      if (trig) begin m_val = pick(nw, s); m_cnt = 9; end
    end else if (m_cnt == 1) begin
      m_hex2 = seg(m_val / 100);
      m_hex1 = seg((m_val / 10) % 10);
      m_hex0 = seg(m_val % 10);
      m_done = 1'b1;
      if (m_pend || trig) begin
        m_val = pick(nw, s); m_cnt = 9; m_pend = 1'b0;
      end else begin
        m_cnt = 0;
      end
    end else begin
      m_cnt--;
      if (trig) m_pend = 1'b1;
    end
    m_word = nw;
    m_ok   = m_ok | dv;
    m_sel  = s;
  endtask

  task automatic check_outputs();
    chk("hex0", 32'(bus.hex0), 32'(m_hex0));
    chk("hex1", 32'(bus.hex1), 32'(m_hex1));
    chk("hex2", 32'(bus.hex2), 32'(m_hex2));
    chk("busy", 32'(bus.busy), 32'(m_cnt != 0));
    chk("done", 32'(bus.done), 32'(m_done));
  endtask

  task automatic step(input logic dv, input logic [127:0] d, input logic [3:0] s);
    @(negedge clk);
    bus.data_valid = dv;
    bus.data_in    = d;
    bus.sel        = s;
    @(posedge clk);
    model_edge(dv, d, s);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic [3:0] s);
    for (int i = 0; i < n; i++) step(1'b0, '0, s);
  endtask

  // Follows one conversion started now and checks the partial BCD after
  // each shift: after i shifts it equals the decimal of the top i bits.
  task automatic boundary(input logic [127:0] w, input logic [3:0] s);
    int v;
    v = pick(w, s);
    step(1'b1, w, s);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, '0, s);
      chk("bcd_step", 32'(dut.bcd_q), 32'(to_bcd(v >> (8 - i))));
    end
    step(1'b0, '0, s);
    chk("bnd_hex2", 32'(bus.hex2), 32'(seg(v / 100)));
    chk("bnd_hex1", 32'(bus.hex1), 32'(seg((v / 10) % 10)));
    chk("bnd_hex0", 32'(bus.hex0), 32'(seg(v % 10)));
    idle(2, s);
  endtask

  initial begin
    logic [127:0] bw;
    int done_cnt, busy_cnt;
    logic [3:0] rs;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    bus.sel        = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hex0", 32'(bus.hex0), 32'h7f);
    chk("rst_hex1", 32'(bus.hex1), 32'h7f);
    chk("rst_hex2", 32'(bus.hex2), 32'h7f);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // sel toggling before any capture is ignored
    for (int i = 0; i < 6; i++) step(1'b0, '0, 4'(i * 5));
    chk("pre_busy", 32'(bus.busy), 32'h0);
    chk("pre_hex0", 32'(bus.hex0), 32'h7f);

    // 0x69 = 105
    step(1'b1, VEC, 4'd0);
    idle(8, 4'd0);
    chk("v0_done_early", 32'(bus.done), 32'h0);
    step(1'b0, '0, 4'd0);
    chk("v0_hex2", 32'(bus.hex2), 32'b1111001);
    chk("v0_hex1", 32'(bus.hex1), 32'b1000000);
    chk("v0_hex0", 32'(bus.hex0), 32'b0010010);
    chk("v0_done", 32'(bus.done), 32'h1);
    idle(3, 4'd0);

    // 0xe0 = 224
    idle(10, 4'd2);
    chk("v2_hex2", 32'(bus.hex2), 32'b0100100);
    chk("v2_hex1", 32'(bus.hex1), 32'b0100100);
    chk("v2_hex0", 32'(bus.hex0), 32'b0011001);
    idle(2, 4'd2);

    // 0x5a = 90
    idle(10, 4'd15);
    chk("v15_hex2", 32'(bus.hex2), 32'b1000000);
    chk("v15_hex1", 32'(bus.hex1), 32'b0010000);
    chk("v15_hex0", 32'(bus.hex0), 32'b1000000);
    idle(2, 4'd15);

    // boundary bytes 0x00 and 0xff
    bw = '0;
    bw[103:96] = 8'hff;
    boundary(bw, 4'd0);
    boundary(bw, 4'd3);

    // two triggers during a conversion -> one rerun, busy without a gap
    done_cnt = 0;
    busy_cnt = 0;
    step(1'b1, VEC, 4'd1);
    busy_cnt += int'(bus.busy);
    for (int i = 1; i < 26; i++) begin
      rs = (i == 3) ? 4'd4 : (i >= 4) ? 4'd7 : 4'd1;
      step(1'b0, '0, rs);
      done_cnt += int'(bus.done);
      if (i <= 17) busy_cnt += int'(bus.busy);
    end
    chk("rerun_dones", 32'(done_cnt), 32'd2);
    chk("rerun_busy", 32'(busy_cnt), 32'd18);
    chk("rerun_hex0", 32'(bus.hex0), 32'(seg(pick(VEC, 4'd7) % 10)));

    // reset in the middle of a conversion
    step(1'b1, VEC, 4'd5);
    idle(5, 4'd5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_hex0", 32'(bus.hex0), 32'h7f);
    chk("mid_rst_hex2", 32'(bus.hex2), 32'h7f);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.sel = 4'd0;
    step(1'b1, VEC, 4'd6);
    idle(10, 4'd6);
    chk("post_rst_hex0", 32'(bus.hex0), 32'(seg(pick(VEC, 4'd6) % 10)));

    // random traffic
    rs = 4'd6;
    for (int i = 0; i < 400; i++) begin
      logic dv;
      dv = ($urandom_range(7) == 0);
      if ($urandom_range(3) == 0) rs = 4'($urandom_range(15));
      step(dv, {$urandom, $urandom, $urandom, $urandom}, rs);
    end
    idle(20, rs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
